// File: rtl/act_fifo_pkg.sv
// Shared sizing constants for the SRAM-backed activation FIFO and its output buffer.
package act_fifo_pkg;
    localparam int DATA_W     = 64;
    localparam int ADDR_W     = 8;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int OBUF_DEPTH = 2;
    localparam int CNT_W      = ADDR_W + 1;
endpackage

// File: rtl/act_obuf_fifo2.sv
// Two-entry register FIFO that absorbs the one-cycle RAM read latency in front of the consumer.
module act_obuf_fifo2
    import act_fifo_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head,
    output logic [1:0]   cnt
);
    logic [W-1:0] mem_q [OBUF_DEPTH];
    logic [W-1:0] mem_d [OBUF_DEPTH];
    logic         rd_idx_q, rd_idx_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         wr_idx;

    // Write slot sits just behind the head; a push into a full buffer only happens alongside a pop.
    always_comb begin
        mem_d    = mem_q;
        rd_idx_d = rd_idx_q;
        cnt_d    = cnt_q;
        wr_idx   = rd_idx_q ^ cnt_q[0];
        if (flush) begin
            rd_idx_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_idx] = push_data;
            end
            if (pop) begin
                rd_idx_d = ~rd_idx_q;
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_idx_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid = (cnt_q != 2'd0);
    assign head  = mem_q[rd_idx_q];
    assign cnt   = cnt_q;
endmodule

// File: rtl/act_sram_fifo.sv
// Stream FIFO whose bulk storage lives in an external dual-port SRAM (port 0 writes, port 1 reads),
// with a small output buffer that hides the read latency and sustains one word per cycle.
module act_sram_fifo
    import act_fifo_pkg::OBUF_DEPTH;
#(
    parameter int DATA_W = act_fifo_pkg::DATA_W,
    parameter int ADDR_W = act_fifo_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    input  logic              flush,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              ram_ce0,
    output logic              ram_we0,
    output logic [ADDR_W-1:0] ram_addr0,
    output logic [DATA_W-1:0] ram_wd0,
    output logic              ram_ce1,
    output logic              ram_we1,
    output logic [ADDR_W-1:0] ram_addr1,
    input  logic [DATA_W-1:0] ram_rd1
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] RAM_FULL = CNT_W'(1 << ADDR_W);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
    logic              inflight_q, inflight_d;
    logic              push, pop, issue;
    logic [1:0]        obuf_cnt;
    logic [2:0]        pending;

    assign s_ready = rst_n && !flush && (ram_cnt_q < RAM_FULL);
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    // Only issue a read when the buffer is guaranteed a free slot by the time the data returns.
    assign pending = {1'b0, obuf_cnt} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue   = (ram_cnt_q != '0) && !flush && (pending < 3'(OBUF_DEPTH));

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        ram_cnt_d  = ram_cnt_q;
        inflight_d = 1'b0;
        if (!flush) begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (issue) begin
                rptr_d = rptr_q + 1'b1;
            end
            ram_cnt_d  = ram_cnt_q + CNT_W'(push) - CNT_W'(issue);
            inflight_d = issue;
        end else begin
            wptr_d    = '0;
            rptr_d    = '0;
            ram_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    // Returning read data lands in the buffer unless a flush discards it.
    act_obuf_fifo2 #(
        .W(DATA_W)
    ) u_obuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (inflight_q),
        .push_data(ram_rd1),
        .pop      (pop),
        .valid    (m_valid),
        .head     (m_data),
        .cnt      (obuf_cnt)
    );

    assign ram_ce0   = push;
    assign ram_we0   = push;
    assign ram_addr0 = wptr_q;
    assign ram_wd0   = s_data;
    assign ram_ce1   = issue;
    assign ram_we1   = 1'b0;
    assign ram_addr1 = rptr_q;

    assign count = ram_cnt_q + CNT_W'(inflight_q) + CNT_W'(obuf_cnt);
    assign empty = (count == '0);
    assign full  = !s_ready;
endmodule

// File: tb/tb_act_sram_fifo.sv
// Self-checking bench for act_sram_fifo: external RAM model plus a queue-based reference of FIFO contents.
module tb_act_sram_fifo;
    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        flush;
    logic [8:0]  count;
    logic        empty;
    logic        full;
    logic        ram_ce0, ram_we0, ram_ce1, ram_we1;
    logic [7:0]  ram_addr0, ram_addr1;
    logic [63:0] ram_wd0, ram_rd1;

    logic [63:0] mem [256];
    logic [63:0] q [$];
    int          n_cmp;
    int          n_err;
    logic        last_mvalid;
    logic [63:0] last_mdata;
    logic        last_ce1;

    act_sram_fifo #(.DATA_W(64), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .flush(flush), .count(count), .empty(empty), .full(full),
        .ram_ce0(ram_ce0), .ram_we0(ram_we0), .ram_addr0(ram_addr0), .ram_wd0(ram_wd0),
        .ram_ce1(ram_ce1), .ram_we1(ram_we1), .ram_addr1(ram_addr1), .ram_rd1(ram_rd1)
    );

    always #5 clk = ~clk;

    // Synchronous dual-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_ce0 && ram_we0) mem[ram_addr0] <= ram_wd0;
        if (ram_ce1) ram_rd1 <= mem[ram_addr1];
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance the reference queue.
    task automatic applyStimulus(input logic sv, input logic [63:0] sd, input logic mr,
                                 input logic fl, output logic acc, output logic popped);
        s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
        #1;
        checkOutput("full_vs_ready", full, !s_ready);
        if (fl) checkOutput("s_ready_flush", s_ready, 1'b0);
        else if (q.size() < 256) checkOutput("s_ready_room", s_ready, 1'b1);
        else if (q.size() >= 258) checkOutput("s_ready_full", s_ready, 1'b0);
        acc = sv && s_ready;
        checkOutput("ram_ce0", ram_ce0, acc);
        checkOutput("ram_we0", ram_we0, acc);
        if (acc) checkOutput("ram_wd0", ram_wd0, sd);
        checkOutput("ram_we1", ram_we1, 1'b0);
        if (ram_ce0 && ram_ce1) checkOutput("rw_collision", ram_addr0 == ram_addr1, 1'b0);
        popped      = m_valid && mr;
        last_mvalid = m_valid;
        last_mdata  = m_data;
        last_ce1    = ram_ce1;
        if (m_valid) begin
            checkOutput("m_valid_nonempty", q.size() != 0, 1'b1);
            if (q.size() != 0) checkOutput("m_data_order", m_data, q[0]);
        end
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (popped && q.size() != 0) void'(q.pop_front());
            if (acc) q.push_back(sd);
        end
        @(negedge clk);
        checkOutput("count", count, 64'(q.size()));
        checkOutput("empty", empty, q.size() == 0);
    endtask

    task automatic drain();
        logic a, p;
        int   cyc;
        cyc = 0;
        while (q.size() != 0 && cyc < 1000) begin
            applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, a, p);
            cyc++;
        end
        checkOutput("drain_done", q.size(), 64'h0);
    endtask

    initial begin
        logic a, p;
        int   n_acc, n_pop, cyc, c_ref;
        logic saw;
        clk = 1'b0; rst_n = 1'b0; s_valid = 1'b1; s_data = 64'h1234; m_ready = 1'b1; flush = 1'b0;
        n_cmp = 0; n_err = 0;

        // Reset values with s_valid held high
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_s_ready", s_ready, 1'b0);
        checkOutput("rst_m_valid", m_valid, 1'b0);
        checkOutput("rst_count", count, 64'h0);
        checkOutput("rst_empty", empty, 1'b1);
        checkOutput("rst_ram_ce0", ram_ce0, 1'b0);
        checkOutput("rst_ram_we0", ram_we0, 1'b0);
        checkOutput("rst_ram_ce1", ram_ce1, 1'b0);
        s_valid = 1'b0;
        rst_n = 1'b1;
        #1 checkOutput("s_ready_after_reset", s_ready, 1'b1);

        // Single word: m_valid exactly three cycles after the push
        applyStimulus(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0, a, p);
        checkOutput("single_accepted", a, 1'b1);
        checkOutput("single_count1", count, 64'd1);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, a, p);
            if (k < 3) checkOutput("single_lat_early", last_mvalid, 1'b0);
        end
        checkOutput("single_lat_t3", last_mvalid, 1'b1);
        checkOutput("single_data", last_mdata, 64'hDEAD_BEEF_0000_0001);
        checkOutput("single_count0", count, 64'd0);

        // Fill to 258 with the consumer stalled
        n_acc = 0; cyc = 0;
        while (n_acc < 258 && cyc < 400) begin
            applyStimulus(1'b1, 64'h1000 + 64'(n_acc), 1'b0, 1'b0, a, p);
            if (a) n_acc++;
            cyc++;
        end
        checkOutput("fill_accepted", n_acc, 64'd258);
        checkOutput("fill_count", count, 64'd258);
        checkOutput("fill_full", full, 1'b1);
        applyStimulus(1'b1, 64'hFFFF, 1'b0, 1'b0, a, p);
        checkOutput("fill_259_rejected", a, 1'b0);
        drain();

        // Random valid/ready over 1000 incrementing words; pointers wrap several times
        n_acc = 0; n_pop = 0; cyc = 0;
        while ((n_acc < 1000 || q.size() != 0) && cyc < 20000) begin
            applyStimulus((n_acc < 1000) && ($urandom_range(0, 3) != 0), 64'(n_acc),
                          $urandom_range(0, 3) != 0, 1'b0, a, p);
            if (a) n_acc++;
            if (p) n_pop++;
            cyc++;
        end
        checkOutput("wrap_popped", n_pop, 64'd1000);

        // Streaming: one in, one out every cycle once filled
        n_pop = 0; c_ref = 0;
        for (int i = 0; i < 500; i++) begin
            applyStimulus(1'b1, 64'hA000 + 64'(i), 1'b1, 1'b0, a, p);
            if (i == 9) c_ref = int'(count);
            if (i >= 10 && p) n_pop++;
        end
        checkOutput("stream_pops", n_pop, 64'd490);
        checkOutput("stream_count_const", count, 64'(c_ref));
        drain();

        // Flush with 10 words held and a read in flight
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, 64'hB000 + 64'(i), 1'b0, 1'b0, a, p);
        repeat (3) applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, a, p);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, a, p);
        checkOutput("flush_read_issued", last_ce1, 1'b1);
        checkOutput("flush_held10", count, 64'd10);
        applyStimulus(1'b1, 64'hBAD, 1'b0, 1'b1, a, p);
        checkOutput("flush_count", count, 64'd0);
        checkOutput("flush_m_valid", m_valid, 1'b0);
        applyStimulus(1'b1, 64'h5A, 1'b0, 1'b0, a, p);
        cyc = 0;
        last_mvalid = 1'b0;
        while (!last_mvalid && cyc < 10) begin
            applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, a, p);
            cyc++;
        end
        checkOutput("flush_wait", last_mvalid, 1'b1);
        checkOutput("flush_first_out", last_mdata, 64'h5A);

        // Reset pulsed mid-stream
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 64'hC000 + 64'(i), 1'b1, 1'b0, a, p);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_count", count, 64'h0);
        checkOutput("mid_rst_m_valid", m_valid, 1'b0);
        checkOutput("mid_rst_s_ready", s_ready, 1'b0);
        checkOutput("mid_rst_empty", empty, 1'b1);
        checkOutput("mid_rst_ram_ce0", ram_ce0, 1'b0);
        checkOutput("mid_rst_ram_ce1", ram_ce1, 1'b0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        rst_n = 1'b1;
        #1 checkOutput("mid_rst_release_ready", s_ready, 1'b1);
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, a, p);
            if (last_mvalid) saw = 1'b1;
        end
        checkOutput("mid_rst_no_stale", saw, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 64'hD000 + 64'(i), 1'b1, 1'b0, a, p);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/act_sram_fifo.md
ACT_SRAM_FIFO -- requirements
Module: act_sram_fifo

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the word width of the stream and the RAM data ports.
REQ-002 Parameter ADDR_W, default 8, SHALL set the RAM address width; RAM depth is 2**ADDR_W (256).
REQ-003 clk  in  1  single clock; the block's own registers and both RAM port clocks run on clk.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 s_valid  in  1  producer word valid.
REQ-006 s_ready  out  1  block accepts a word this cycle.
REQ-007 s_data  in  DATA_W  producer word.
REQ-008 m_valid  out  1  head word valid to the consumer.
REQ-009 m_ready  in  1  consumer accepts the head word.
REQ-010 m_data  out  DATA_W  head word.
REQ-011 flush  in  1  synchronous discard of all contents.
REQ-012 count  out  ADDR_W+1  total words held (RAM + in-flight + output buffer).
REQ-013 empty  out  1  count==0.  full  out  1  equals !s_ready.
REQ-014 ram_ce0, ram_we0  out  1 each; ram_addr0  out  ADDR_W; ram_wd0  out  DATA_W  write port (rw0).
REQ-015 ram_ce1  out  1; ram_addr1  out  ADDR_W; ram_rd1  in  DATA_W  read port (rw1); ram_we1 is tied 0 by the block.

Function
REQ-016 Push = s_valid && s_ready; on push the block SHALL drive, in the same cycle, ram_ce0=1, ram_we0=1, ram_addr0=wptr, ram_wd0=s_data; otherwise ram_ce0=ram_we0=0.
REQ-017 s_ready SHALL be 1 iff ram_cnt < 2**ADDR_W and flush==0 and not in reset.
REQ-018 wptr and rptr SHALL increment modulo 2**ADDR_W (255 -> 0) on push and read issue respectively.
REQ-019 Read issue SHALL occur iff ram_cnt != 0 and flush==0 and (obuf_cnt + inflight - pop) < 2, where pop = m_valid && m_ready; on issue ram_ce1=1, ram_addr1=rptr.
REQ-020 RAM read latency is one cycle: ram_rd1 is sampled the cycle after issue and written into the 2-entry output buffer (inflight flag 0/1).
REQ-021 ram_cnt SHALL update as +push -issue each cycle; simultaneous push and issue leave it unchanged.
REQ-022 Only slots already counted in ram_cnt are read, so no same-address read/write collision SHALL occur.
REQ-023 m_valid = obuf_cnt != 0; m_data = output-buffer head; order SHALL be strict FIFO.
REQ-024 Latency: push into an empty block at cycle t SHALL give m_valid=1 at cycle t+3.
REQ-025 Throughput: with s_valid and m_ready held 1, one push and one pop SHALL occur every cycle in steady state.
REQ-026 count = ram_cnt + inflight + obuf_cnt, maximum 2**ADDR_W + 2 = 258.
REQ-027 flush SHALL override push, pop and issue: the next cycle pointers, ram_cnt, inflight and obuf_cnt are 0; any returning read data is dropped.

Reset
REQ-028 While rst_n=0: wptr, rptr, ram_cnt, inflight and obuf_cnt are 0; m_valid=0, s_ready=0, count=0, empty=1, all ram_ce*/ram_we0 are 0.
REQ-029 First cycle after rst_n rises: s_ready=1; reset asserted mid-transfer SHALL discard all data, including an in-flight read.

Structure
REQ-030 Package act_fifo_pkg SHALL hold DATA_W, ADDR_W, DEPTH=256, OBUF_DEPTH=2 and CNT_W=ADDR_W+1.
REQ-031 The output buffer SHALL be a sub-module act_obuf_fifo2: 2 entries, push/pop, with flush and async active-low reset.
REQ-032 The RAM is external to the block; the block contains no storage array larger than the 2-entry buffer.

Verification
REQ-033 Single word: push 0xDEAD_BEEF_0000_0001 into an empty FIFO at cycle t with m_ready=1 -> m_valid at t+3 with that data; count goes 1->0 after the pop.
REQ-034 Fill: 258 pushes with m_ready=0 -> s_ready=0 and full=1 after word 258, count=258; the 259th s_valid is not accepted.
REQ-035 Wrap: stream 1000 incrementing words with random s_valid/m_ready -> output identical and in order; pointers pass 255->0 without loss.
REQ-036 Streaming: s_valid=m_ready=1 for 500 cycles -> after a 3-cycle fill, one word out per cycle and count stays constant.
REQ-037 Flush with 10 words held and a read in flight -> next cycle count=0, m_valid=0; the next pushed word 0x5A is the first output.
REQ-038 rst_n pulsed low mid-stream -> outputs take the REQ-028 values immediately; after release, s_ready=1 and no stale word appears.
